cpu_exec_core: RTL and testbench

CPU_EXEC_CORE -- requirements
Module: cpu_exec_core

---
 rtl/exec_pkg.sv | 24 ++
 rtl/cpu_exec_core_if.sv | 28 ++
 rtl/exec_phase_ring.sv | 24 ++
 rtl/cpu_exec_core.sv | 112 +++++++++++
 tb/tb_cpu_exec_core.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared constants for the multi-cycle execute core: opcodes, phase indices
// and the step selector type used by cpu_exec_core.
package exec_pkg;

    localparam int NUM_PHASES = 12;
    localparam int PH_STEP1   = 4;
    localparam int PH_STEP2   = 6;
    localparam int PH_STEP3   = 8;
    localparam int PH_CLEAR   = 10;
    localparam int LOAD_NONE  = 0;

    localparam logic [7:0] OP_PUSH_EBP  = 8'h55;
    localparam logic [7:0] OP_PUSH_IMM8 = 8'h6a;
    localparam logic [7:0] OP_MOV_RM_R  = 8'h89;
    localparam logic [7:0] OP_MOV_R_RM  = 8'h8b;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_1,
        STEP_2,
        STEP_3
    } step_e;

endpackage

// File: rtl/cpu_exec_core_if.sv
// Operand/result bundle between the decode side and the execute core.
// master drives instruction operands, slave returns the registered result.
interface cpu_exec_core_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
);
    logic [31:0]       ope;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] reg_in;
    logic [3:0]        num_of_ope;
    logic [SEL_W-1:0]  reg_load_1;
    logic [SEL_W-1:0]  reg_load_2;
    logic [SEL_W-1:0]  reg_load_3;
    logic [DATA_W-1:0] alu_result_bus;
    logic [SEL_W-1:0]  selected_reg_load;

    modport master (
        output ope, imm, reg_in, num_of_ope,
        output reg_load_1, reg_load_2, reg_load_3,
        input  alu_result_bus, selected_reg_load
    );

    modport slave (
        input  ope, imm, reg_in, num_of_ope,
        input  reg_load_1, reg_load_2, reg_load_3,
        output alu_result_bus, selected_reg_load
    );
endinterface

// File: rtl/exec_phase_ring.sv
// 12-phase one-hot ring; empty while in reset, restarts at phase 1.
module exec_phase_ring
    import exec_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    output logic [NUM_PHASES-1:0] phase_o
);

    logic [NUM_PHASES-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = {phase_q[NUM_PHASES-2:0], phase_q[NUM_PHASES-1]};
        if (phase_q == '0) phase_d = NUM_PHASES'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) phase_q <= '0;
        else       phase_q <= phase_d;
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/cpu_exec_core.sv
// Three-step execute core sequenced by a 12-phase ring.
// Define EXEC_IMM8_SIGN_EXT_EN to sign-extend imm8 for push imm8.
module cpu_exec_core
    import exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    cpu_exec_core_if.slave   bus,
    output logic             clock_1,
    output logic             clock_2,
    output logic             clock_3,
    output logic             clock_4,
    output logic             clock_5,
    output logic             clock_6,
    output logic             clock_7,
    output logic             clock_8,
    output logic             clock_9,
    output logic             clock_10,
    output logic             clock_11,
    output logic             clock_12
);

    logic [NUM_PHASES-1:0] phase;
    step_e                 step;
    logic [7:0]            opcode;
    logic [DATA_W-1:0]     imm8_ext, sum_imm, dec4, inc_len;
    logic [DATA_W-1:0]     alu_q, alu_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  unused_ope;

    exec_phase_ring u_ring (
        .clk     (clk),
        .reset   (reset),
        .phase_o (phase)
    );

    assign opcode     = bus.ope[31:24];
    assign unused_ope = ^bus.ope[15:0];

`ifdef EXEC_IMM8_SIGN_EXT_EN
    assign imm8_ext = {{(DATA_W-8){bus.ope[23]}}, bus.ope[23:16]};
`else
    assign imm8_ext = {{(DATA_W-8){1'b0}}, bus.ope[23:16]};
`endif

    assign sum_imm = bus.reg_in + bus.imm;
    assign dec4    = bus.reg_in - DATA_W'(4);
    assign inc_len = bus.reg_in + DATA_W'(bus.num_of_ope);

    always_comb begin
        step = STEP_NONE;
        unique case (1'b1)
            phase[PH_STEP1-1]: step = STEP_1;
            phase[PH_STEP2-1]: step = STEP_2;
            phase[PH_STEP3-1]: step = STEP_3;
            default:           step = STEP_NONE;
        endcase
    end

    always_comb begin
        alu_d = alu_q;
        sel_d = sel_q;
        case (step)
            STEP_1: begin
                sel_d = bus.reg_load_1;
                if (opcode == OP_PUSH_EBP || opcode == OP_PUSH_IMM8)
                    alu_d = dec4;
                else if (opcode == OP_MOV_RM_R || opcode == OP_MOV_R_RM)
                    alu_d = bus.reg_in;
                else
                    alu_d = sum_imm;
            end
            STEP_2: begin
                sel_d = bus.reg_load_2;
                if (opcode == OP_PUSH_IMM8)
                    alu_d = imm8_ext;
                else if (opcode == OP_PUSH_EBP || opcode == OP_MOV_RM_R
                         || opcode == OP_MOV_R_RM)
                    alu_d = bus.reg_in;
                else
                    alu_d = sum_imm;
            end
            STEP_3: begin
                sel_d = bus.reg_load_3;
                alu_d = inc_len;
            end
            default: begin
                if (phase[PH_CLEAR-1]) sel_d = SEL_W'(LOAD_NONE);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_q <= '0;
            sel_q <= '0;
        end else begin
            alu_q <= alu_d;
            sel_q <= sel_d;
        end
    end

    assign bus.alu_result_bus    = alu_q;
    assign bus.selected_reg_load = sel_q;

    assign {clock_12, clock_11, clock_10, clock_9, clock_8, clock_7,
            clock_6, clock_5, clock_4, clock_3, clock_2, clock_1} = phase;

endmodule

// File: tb/tb_cpu_exec_core.sv
// Randomized bench for cpu_exec_core against a phase-counting reference model.
// Build with EXEC_IMM8_SIGN_EXT_EN defined to exercise the sign-extend variant.
module tb_cpu_exec_core;

    logic clk = 1'b0;
    logic reset;
    logic [11:0] strb;
    logic c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12;

    int n_chk = 0;
    int n_err = 0;

    int          ph;
    logic [31:0] e_alu;
    logic [3:0]  e_sel;

    cpu_exec_core_if #(.DATA_W(32), .SEL_W(4)) bus ();

    cpu_exec_core #(.DATA_W(32), .SEL_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .clock_1  (c1),
        .clock_2  (c2),
        .clock_3  (c3),
        .clock_4  (c4),
        .clock_5  (c5),
        .clock_6  (c6),
        .clock_7  (c7),
        .clock_8  (c8),
        .clock_9  (c9),
        .clock_10 (c10),
        .clock_11 (c11),
        .clock_12 (c12)
    );

    assign strb = {c12, c11, c10, c9, c8, c7, c6, c5, c4, c3, c2, c1};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input int s,
        input logic [31:0] op, input logic [31:0] ri,
        input logic [31:0] im, input logic [3:0] n);
        logic [7:0]  o;
        logic [31:0] e;
        o = op[31:24];
        e = 32'(op[23:16]);
`ifdef EXEC_IMM8_SIGN_EXT_EN
        if (e >= 32'd128) e = e - 32'd256;
`endif
        if (s == 3) return ri + 32'(n);
        case (o)
            8'h55:        return (s == 1) ? ri - 32'd4 : ri;
            8'h6a:        return (s == 1) ? ri - 32'd4 : e;
            8'h89, 8'h8b: return ri;
            default:      return ri + im;
        endcase
    endfunction

    // one clock: update the model at the edge, compare at the falling edge
    task automatic cyc();
        @(posedge clk);
        if (reset) begin
            ph = 0; e_alu = '0; e_sel = '0;
        end else begin
            case (ph)
                4: begin
                    e_alu = ref_step(1, bus.ope, bus.reg_in, bus.imm, bus.num_of_ope);
                    e_sel = bus.reg_load_1;
                end
                6: begin
                    e_alu = ref_step(2, bus.ope, bus.reg_in, bus.imm, bus.num_of_ope);
                    e_sel = bus.reg_load_2;
                end
                8: begin
                    e_alu = ref_step(3, bus.ope, bus.reg_in, bus.imm, bus.num_of_ope);
                    e_sel = bus.reg_load_3;
                end
                10: e_sel = '0;
                default: ;
            endcase
            ph = (ph == 0) ? 1 : (ph % 12) + 1;
        end
        @(negedge clk);
        chk("strobes", 64'(strb), (ph == 0) ? 64'd0 : 64'(12'd1 << (ph - 1)));
        chk("alu", 64'(bus.alu_result_bus), 64'(e_alu));
        chk("sel", 64'(bus.selected_reg_load), 64'(e_sel));
    endtask

    task automatic rand_inputs();
        case ($urandom_range(0, 4))
            0:       bus.ope[31:24] = 8'h55;
            1:       bus.ope[31:24] = 8'h6a;
            2:       bus.ope[31:24] = 8'h89;
            3:       bus.ope[31:24] = 8'h8b;
            default: bus.ope[31:24] = 8'($urandom);
        endcase
        bus.ope[23:0]  = 24'($urandom);
        bus.imm        = $urandom;
        bus.reg_in     = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        bus.num_of_ope = 4'($urandom);
        bus.reg_load_1 = 4'($urandom);
        bus.reg_load_2 = 4'($urandom);
        bus.reg_load_3 = 4'($urandom);
    endtask

    task automatic align(input int target);
        int k;
        k = 0;
        while (ph != target && k < 30) begin
            rand_inputs();
            cyc();
            k++;
        end
        if (ph != target) chk("align_timeout", 64'(ph), 64'(target));
    endtask

    // holds one instruction for a full ring period, checking step values
    task automatic dir_seq(input string tag, input logic [31:0] op,
        input logic [31:0] ri, input logic [3:0] n,
        input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] x3);
        align(12);
        bus.ope = op; bus.reg_in = ri; bus.num_of_ope = n;
        bus.reg_load_1 = 4'd3; bus.reg_load_2 = 4'd5; bus.reg_load_3 = 4'd1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (ph == 5) begin
                chk({tag, "_s1"}, 64'(bus.alu_result_bus), 64'(x1));
                chk({tag, "_sel5"}, 64'(bus.selected_reg_load), 64'd3);
            end
            if (ph == 7) begin
                chk({tag, "_s2"}, 64'(bus.alu_result_bus), 64'(x2));
                chk({tag, "_sel7"}, 64'(bus.selected_reg_load), 64'd5);
            end
            if (ph == 9) begin
                chk({tag, "_s3"}, 64'(bus.alu_result_bus), 64'(x3));
                chk({tag, "_sel10"}, 64'(bus.selected_reg_load), 64'd1);
            end
            if (ph == 11) chk({tag, "_sel11"}, 64'(bus.selected_reg_load), 64'd0);
            chk({tag, "_onehot"}, 64'($countones(strb)), 64'd1);
        end
    endtask

    initial begin
        logic [31:0] x2_fe;
        ph = 0; e_alu = '0; e_sel = '0;
        reset = 1'b1;
        rand_inputs();
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_alu", 64'(bus.alu_result_bus), 64'd0);
        reset = 1'b0;
        cyc();
        chk("first_c1", 64'(c1), 64'd1);

        for (int i = 0; i < 24; i++) begin
            rand_inputs();
            cyc();
            chk("ring_onehot", 64'($countones(strb)), 64'd1);
        end

        dir_seq("push6a", 32'h6a080000, 32'h00001000, 4'd2,
                32'h00000FFC, 32'h00000008, 32'h00001002);
`ifdef EXEC_IMM8_SIGN_EXT_EN
        x2_fe = 32'hFFFFFFFE;
`else
        x2_fe = 32'h000000FE;
`endif
        dir_seq("pushFE", 32'h6aFE0000, 32'h00000010, 4'd3,
                32'h0000000C, x2_fe, 32'h00000013);
        dir_seq("wrap", 32'h55000000, 32'h00000000, 4'd0,
                32'hFFFFFFFC, 32'h00000000, 32'h00000000);
        dir_seq("mov", 32'h8b000000, 32'h12345678, 4'd15,
                32'h12345678, 32'h12345678, 32'h12345687);

        // abort in phase 5; steps resume only after phases 1..4 replay
        align(5);
        reset = 1'b1;
        cyc();
        chk("abort_strb", 64'(strb), 64'd0);
        chk("abort_alu", 64'(bus.alu_result_bus), 64'd0);
        chk("abort_sel", 64'(bus.selected_reg_load), 64'd0);
        reset = 1'b0;
        bus.ope = 32'h55000000; bus.reg_in = 32'h100; bus.reg_load_1 = 4'd7;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("replay_ph", 64'(strb), 64'(12'd1 << (i - 1)));
            chk("replay_alu", 64'(bus.alu_result_bus), 64'd0);
        end
        cyc();
        chk("resume_s1", 64'(bus.alu_result_bus), 64'h000000FC);
        chk("resume_sel", 64'(bus.selected_reg_load), 64'd7);

        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            reset = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
